// File: rtl/rotary_position_tracker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : rotary_position_tracker
// Description : Debounced quadrature decode of two dials into saturating X/Y
//               cursor positions, exposed over an Avalon-MM register slave.
// Revision    : 1.0
// ============================================================================
module rotary_position_tracker #(
   parameter int DEBOUNCE_CYCLES  = 500,
   parameter int X_MAX            = 479,
   parameter int Y_MAX            = 271,
   parameter int TRANS_PER_DETENT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  dial_l,
   input  logic [1:0]  dial_r,
   input  logic [1:0]  avs_address,
   input  logic        avs_read,
   output logic [31:0] avs_readdata,
   input  logic        avs_write,
   input  logic [31:0] avs_writedata,
   output logic        changed
);
   localparam int                 c_cnt_w    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
   localparam logic [8:0]         c_x_max    = 9'(X_MAX);
   localparam logic [8:0]         c_y_max    = 9'(Y_MAX);
   localparam logic [3:0]         c_tpd_pos  = 4'(TRANS_PER_DETENT);
   localparam logic [3:0]         c_tpd_neg  = 4'(-TRANS_PER_DETENT);

   // Bits [1:0] belong to the left dial, [3:2] to the right dial.
   logic [3:0]         w_raw;
   logic [3:0]         r_sync1;
   logic [3:0]         r_sync2;
   logic [3:0]         r_sync_prev;
   logic [3:0]         r_filt;
   logic [3:0]         r_filt_prev;
   logic [c_cnt_w-1:0] r_cnt [4];

   logic [1:0][8:0]    w_pos;
   logic [1:0]         w_err;
   logic [1:0]         w_moved;
   logic               r_changed;
   logic               w_chg_clr;
   logic [31:0]        w_rdata;
   logic [31:0]        r_rdata;
   logic               w_unused;

   assign w_raw    = {dial_r, dial_l};
   assign w_unused = &{1'b0, avs_writedata[31:9]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1     <= '0;
         r_sync2     <= '0;
         r_sync_prev <= '0;
         r_filt      <= '0;
         r_filt_prev <= '0;
         for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
      end else begin
         r_sync1     <= w_raw;
         r_sync2     <= r_sync1;
         r_sync_prev <= r_sync2;
         r_filt_prev <= r_filt;
         // The counter only runs while a new value stays put; any wobble restarts it.
         for (int i = 0; i < 4; i++) begin
            if (r_sync2[i] == r_filt[i] || r_sync2[i] != r_sync_prev[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == c_cnt_last) begin
               r_filt[i] <= r_sync2[i];
               r_cnt[i]  <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + 1'b1;
            end
         end
      end
   end

   for (genvar d = 0; d < 2; d++) begin : g_dial
      localparam logic [8:0] c_max = (d == 0) ? c_x_max : c_y_max;

      logic [1:0]       w_prev;
      logic [1:0]       w_cur;
      logic [3:0]       w_delta;
      logic [3:0]       w_sum;
      logic             w_bad;
      logic             w_cw;
      logic             w_ccw;
      logic             w_pos_wr;
      logic             w_err_clr;
      logic [8:0]       w_wr_val;
      logic signed [2:0] r_acc;
      logic [8:0]       r_pos;
      logic             r_err;

      assign w_prev = r_filt_prev[2*d +: 2];
      assign w_cur  = r_filt[2*d +: 2];

      always_comb begin
         w_delta = 4'd0;
         w_bad   = 1'b0;
         case ({w_prev, w_cur})
            4'b0001, 4'b0111, 4'b1110, 4'b1000: w_delta = 4'd1;
            4'b0100, 4'b1101, 4'b1011, 4'b0010: w_delta = 4'hF;
            4'b0011, 4'b1100, 4'b0110, 4'b1001: w_bad   = 1'b1;
            default: ;
         endcase
      end

      assign w_sum     = {r_acc[2], r_acc} + w_delta;
      assign w_cw      = (w_sum == c_tpd_pos);
      assign w_ccw     = (w_sum == c_tpd_neg);
      assign w_pos_wr  = avs_write && (avs_address == 2'(d));
      assign w_err_clr = avs_write && (avs_address == 2'd2) && avs_writedata[d];
      assign w_wr_val  = (avs_writedata[8:0] > c_max) ? c_max : avs_writedata[8:0];
      // A bus write owns the position for this cycle, so a coincident step is dropped.
      assign w_moved[d] = !w_pos_wr &&
                          ((w_cw && r_pos != c_max) || (w_ccw && r_pos != 9'd0));
      assign w_pos[d]   = r_pos;
      assign w_err[d]   = r_err;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            r_acc <= '0;
            r_pos <= '0;
            r_err <= 1'b0;
         end else begin
            if (w_pos_wr) begin
               r_pos <= w_wr_val;
               r_acc <= '0;
            end else begin
               r_acc <= (w_cw || w_ccw) ? 3'sd0 : signed'(w_sum[2:0]);
               if (w_cw && r_pos != c_max) begin
                  r_pos <= r_pos + 9'd1;
               end else if (w_ccw && r_pos != 9'd0) begin
                  r_pos <= r_pos - 9'd1;
               end
            end
            r_err <= w_bad | (r_err & ~w_err_clr);
         end
      end
   end

   assign w_chg_clr = avs_write && (avs_address == 2'd2) && avs_writedata[2];

   always_comb begin
      w_rdata = '0;
      case (avs_address)
         2'd0:    w_rdata = {23'd0, w_pos[0]};
         2'd1:    w_rdata = {23'd0, w_pos[1]};
         2'd2:    w_rdata = {29'd0, r_changed, w_err[1], w_err[0]};
         default: w_rdata = {7'd0, c_y_max, 7'd0, c_x_max};
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_changed <= 1'b0;
         r_rdata   <= '0;
      end else begin
         r_changed <= (|w_moved) | (r_changed & ~w_chg_clr);
         if (avs_read) r_rdata <= w_rdata;
      end
   end

   assign avs_readdata = r_rdata;
   assign changed      = r_changed;

endmodule
`default_nettype wire

// File: tb/tb_rotary_position_tracker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_rotary_position_tracker
// Description : Directed plus random dial stimulus against a detent-level model.
// Revision    : 1.0
// ============================================================================
module tb_rotary_position_tracker;
   localparam int c_db    = 500;
   localparam int c_x_max = 479;
   localparam int c_y_max = 271;
   localparam int c_tpd   = 4;
   localparam int c_hold  = 600;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  dial_l;
   logic [1:0]  dial_r;
   logic [1:0]  avs_address;
   logic        avs_read;
   logic [31:0] avs_readdata;
   logic        avs_write;
   logic [31:0] avs_writedata;
   logic        changed;

   int total = 0;
   int bad   = 0;

   int         m_pos [2];
   int         m_acc [2];
   int         m_max [2];
   bit         m_err [2];
   bit         m_chg;
   logic [1:0] m_prev [2];
   logic [1:0] raw [2];

   always #5 clk = ~clk;

   rotary_position_tracker #(
      .DEBOUNCE_CYCLES (c_db),
      .X_MAX           (c_x_max),
      .Y_MAX           (c_y_max),
      .TRANS_PER_DETENT(c_tpd)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .dial_l       (dial_l),
      .dial_r       (dial_r),
      .avs_address  (avs_address),
      .avs_read     (avs_read),
      .avs_readdata (avs_readdata),
      .avs_write    (avs_write),
      .avs_writedata(avs_writedata),
      .changed      (changed)
   );

   // Position of a {B,A} code along the clockwise Gray cycle.
   function automatic int gidx(input logic [1:0] v);
      case (v)
         2'b00:   return 0;
         2'b01:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   function automatic logic [1:0] gval(input int k);
      case (((k % 4) + 4) % 4)
         0:       return 2'b00;
         1:       return 2'b01;
         2:       return 2'b11;
         default: return 2'b10;
      endcase
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_pos[d]  = 0;
         m_acc[d]  = 0;
         m_err[d]  = 1'b0;
         m_prev[d] = 2'b00;
      end
      m_chg = 1'b0;
   endtask

   task automatic model_settle(input int d);
      int diff;
      diff = (gidx(raw[d]) - gidx(m_prev[d]) + 4) % 4;
      m_prev[d] = raw[d];
      if (diff == 2) begin
         m_err[d] = 1'b1;
      end else if (diff != 0) begin
         m_acc[d] += (diff == 1) ? 1 : -1;
         if (m_acc[d] == c_tpd) begin
            m_acc[d] = 0;
            if (m_pos[d] < m_max[d]) begin m_pos[d]++; m_chg = 1'b1; end
         end else if (m_acc[d] == -c_tpd) begin
            m_acc[d] = 0;
            if (m_pos[d] > 0) begin m_pos[d]--; m_chg = 1'b1; end
         end
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic move(input logic [1:0] l, input logic [1:0] r, input int cycles);
      raw[0] = l;
      raw[1] = r;
      dial_l = l;
      dial_r = r;
      repeat (cycles) @(posedge clk);
      #1;
      if (cycles >= c_db + 50) begin
         model_settle(0);
         model_settle(1);
      end
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      avs_address = a;
      avs_read    = 1'b1;
      @(posedge clk); #1;
      avs_read = 1'b0;
      d = avs_readdata;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] data);
      int v;
      avs_address   = a;
      avs_writedata = data;
      avs_write     = 1'b1;
      @(posedge clk); #1;
      avs_write = 1'b0;
      if (a < 2) begin
         v = int'(data[8:0]);
         m_pos[a] = (v > m_max[a]) ? m_max[a] : v;
         m_acc[a] = 0;
      end else if (a == 2) begin
         if (data[0]) m_err[0] = 1'b0;
         if (data[1]) m_err[1] = 1'b0;
         if (data[2]) m_chg    = 1'b0;
      end
   endtask

   task automatic check_all(input string tag);
      logic [31:0] d;
      rd(2'd0, d);
      check({tag, ".x"}, d, 32'(m_pos[0]));
      rd(2'd1, d);
      check({tag, ".y"}, d, 32'(m_pos[1]));
      rd(2'd2, d);
      check({tag, ".status"}, d, {29'd0, m_chg, m_err[1], m_err[0]});
      check({tag, ".changed"}, {31'd0, changed}, {31'd0, m_chg});
   endtask

   initial begin
      logic [31:0] d;
      logic [31:0] held;
      int          b;
      bit          saved_chg;

      m_max[0] = c_x_max;
      m_max[1] = c_y_max;
      reset = 1'b1;
      dial_l = 2'b00; dial_r = 2'b00;
      raw[0] = 2'b00; raw[1] = 2'b00;
      avs_address = 2'd0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Reset state
      check("rst.readdata", avs_readdata, 32'd0);
      check("rst.changed", {31'd0, changed}, 32'd0);
      check_all("rst");

      // Left dial: one clean clockwise detent
      for (int k = 1; k <= 4; k++) move(gval(k), raw[1], c_hold);
      check_all("cw_detent");
      rd(2'd0, d);
      check("cw_detent.x_is_1", d, 32'd1);
      rd(2'd2, d);
      check("cw_detent.status_4", d, 32'h4);
      wr(2'd2, 32'h4);
      check("w1c.changed", {31'd0, changed}, {31'd0, m_chg});

      // Right dial: two CCW detents against the zero floor, then clamp and ceiling
      for (int k = 1; k <= 8; k++) move(raw[0], gval(-k), c_hold);
      check_all("ccw_floor");
      wr(2'd1, 32'd300);
      rd(2'd1, d);
      check("y_clamp", d, 32'd271);
      for (int k = 1; k <= 4; k++) move(raw[0], gval(k), c_hold);
      check_all("cw_ceiling");

      // Short bounce on left A never reaches the decoder
      dial_l = raw[0] ^ 2'b01;
      repeat (200) @(posedge clk);
      #1;
      move(raw[0], raw[1], c_hold);
      check_all("bounce");
      b = gidx(raw[0]);
      for (int k = 1; k <= 3; k++) move(gval(b + k), raw[1], c_hold);
      for (int k = 2; k >= 0; k--) move(gval(b + k), raw[1], c_hold);
      check_all("reverse_middetent");

      // Double-bit jump flags an error without moving
      move(gval(gidx(raw[0]) + 2), raw[1], c_hold);
      check_all("invalid");
      wr(2'd2, 32'h1);
      check_all("invalid_clr");

      // Read and write in the same cycle return the pre-write value
      avs_address = 2'd0; avs_writedata = 32'd5; avs_read = 1'b1; avs_write = 1'b1;
      @(posedge clk); #1;
      avs_read = 1'b0; avs_write = 1'b0;
      check("rdwr.old_value", avs_readdata, 32'(m_pos[0]));
      held = avs_readdata;
      m_pos[0] = 5;
      m_acc[0] = 0;
      repeat (5) @(posedge clk);
      #1;
      check("readdata_hold", avs_readdata, held);
      rd(2'd3, d);
      check("const_reg", d, {7'd0, 9'd271, 7'd0, 9'd479});
      wr(2'd3, 32'hFFFF_FFFF);
      check_all("const_write_ignored");

      // Bus write held across the cycle a CW step is produced
      wr(2'd2, 32'h7);
      b = gidx(raw[0]);
      for (int k = 1; k <= 3; k++) move(gval(b + k), raw[1], c_hold);
      saved_chg = m_chg;
      avs_address = 2'd0; avs_writedata = 32'd100; avs_write = 1'b1;
      move(gval(b + 4), raw[1], c_hold);
      avs_write = 1'b0;
      m_pos[0] = 100;
      m_acc[0] = 0;
      m_chg    = saved_chg;
      check_all("collision");

      // Reset in the middle of a detent discards partial progress
      b = gidx(raw[0]);
      for (int k = 1; k <= 2; k++) move(gval(b + k), raw[1], c_hold);
      dial_l = gval(b + 3);
      raw[0] = dial_l;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      model_reset();
      check("rst2.readdata", avs_readdata, 32'd0);
      move(raw[0], raw[1], c_hold);
      move(gval(b + 4), raw[1], c_hold);
      check_all("rst_middetent");
      rd(2'd0, d);
      check("rst_middetent.x_zero", d, 32'd0);

      // Random walk on both dials
      for (int it = 0; it < 30; it++) begin
         logic [1:0] nv [2];
         for (int dd = 0; dd < 2; dd++) begin
            int r;
            r = int'($urandom_range(0, 19));
            if (r < 9)       nv[dd] = gval(gidx(raw[dd]) + 1);
            else if (r < 18) nv[dd] = gval(gidx(raw[dd]) - 1);
            else if (r == 18) nv[dd] = gval(gidx(raw[dd]) + 2);
            else             nv[dd] = raw[dd];
         end
         move(nv[0], nv[1], 560 + int'($urandom_range(0, 80)));
         if (it % 5 == 4) begin
            check_all("random");
            if ($urandom_range(0, 1) == 1) wr(2'd2, 32'h7);
            if ($urandom_range(0, 3) == 0) wr(2'($urandom_range(0, 1)), 32'($urandom_range(0, 511)));
         end
      end
      check_all("random_end");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
